// File: rtl/sata_pkg.sv
// Shared SATA constants, Register H2D FIS field layout and IDENTIFY error causes.
// Latency: none (types, constants and a pure combinational helper).
// Backpressure: not applicable.
package sata_pkg;

    localparam logic [7:0] FIS_TYPE_REG_H2D = 8'h27;
    localparam logic [7:0] ATA_CMD_IDENTIFY = 8'hEC;
    localparam logic [7:0] REG_H2D_C_BIT    = 8'h80;
    localparam int         REG_H2D_LEN      = 5;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TX      = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_CRC     = 2'd3
    } identify_err_t;

    // Command-level fields of a Register H2D FIS; the C bit is always set by the sender.
    typedef struct packed {
        logic [7:0]  command;
        logic [15:0] features;
        logic [47:0] lba;
        logic [7:0]  device;
        logic [15:0] count;
        logic [7:0]  control;
    } reg_h2d_t;

    // Dword idx of the FIS, byte 0 in bits [7:0].
    function automatic logic [31:0] reg_h2d_dword(input reg_h2d_t f, input logic [2:0] idx);
        logic [31:0] d;
        d = '0;
        case (idx)
            3'd0:    d = {f.features[7:0], f.command, REG_H2D_C_BIT, FIS_TYPE_REG_H2D};
            3'd1:    d = {f.device, f.lba[23:0]};
            3'd2:    d = {f.features[15:8], f.lba[47:24]};
            3'd3:    d = {f.control, 8'h00, f.count};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sata_reg_h2d_fis_tx.sv
// Streams a 5-dword Register H2D FIS to the transport layer; sent marks the last dword's handshake.
// Latency: first dword valid the cycle after launch; one dword per cycle with cmd_rdy high.
// Backpressure: a dword is held on cmd_dat while cmd_rdy is low; abort drops cmd_val next cycle.
module sata_reg_h2d_fis_tx
    import sata_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        launch,
    input  logic        abort,
    input  reg_h2d_t    fis,
    output logic [31:0] cmd_dat,
    output logic        cmd_val,
    output logic        cmd_eop,
    input  logic        cmd_rdy,
    output logic        sent
);

    localparam logic [2:0] LAST_IDX = 3'(REG_H2D_LEN - 1);

    logic     active;
    logic [2:0] idx;
    reg_h2d_t fis_q;

    // Capture fields on launch and step through dwords on each accepted handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            idx    <= '0;
            fis_q  <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (launch) begin
            active <= 1'b1;
            idx    <= '0;
            fis_q  <= fis;
        end else if (active && cmd_rdy) begin
            if (idx == LAST_IDX) begin
                active <= 1'b0;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    assign cmd_val = active;
    assign cmd_eop = active && (idx == LAST_IDX);
    assign cmd_dat = active ? reg_h2d_dword(fis_q, idx) : 32'h0;
    assign sent    = active && cmd_rdy && (idx == LAST_IDX);

endmodule

// File: rtl/sata_identify_ctrl.sv
// Runs IDENTIFY DEVICE after link-up: sends the 0xEC FIS, waits for the parser, retries, reports.
// Latency: FIS starts the cycle after start; done/error the cycle after the deciding event.
// Backpressure: FIS stalls on cmd_rdy (timeout not running); SATA_IDENTIFY_CTRL_AUTOSTART_EN adds link-up autostart.
module sata_identify_ctrl
    import sata_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2**24,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        link_ready,
    output logic [31:0] cmd_dat,
    output logic        cmd_val,
    output logic        cmd_eop,
    input  logic        cmd_rdy,
    input  logic        tx_done,
    input  logic        tx_fail,
    input  logic        identify_done,
    input  logic        bad_checksum,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [1:0]  attempt_cnt
);

    localparam int              TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_DATA, RETRY, DONE, FAIL} state_t;

    state_t          state, state_nxt;
    identify_err_t   cause_q, cause_nxt, fail_code;
    logic            fail_code_vld;
    logic            accept, launch, abort, tx_sent, start_eff, tmo_hit, id_rise, id_prev;
    logic [TMO_W-1:0] tmo_cnt;
    reg_h2d_t        identify_fis;

`ifdef SATA_IDENTIFY_CTRL_AUTOSTART_EN
    logic link_prev;

    // Remember link_ready so a link-up edge in IDLE can launch a run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) link_prev <= 1'b0;
        else          link_prev <= link_ready;
    end

    assign start_eff = start || (link_ready && !link_prev);
`else
    assign start_eff = start;
`endif

    // IDENTIFY carries only the command byte; everything else is zero.
    always_comb begin
        identify_fis         = '0;
        identify_fis.command = ATA_CMD_IDENTIFY;
    end

    assign busy    = (state == SEND) || (state == WAIT_TX) || (state == WAIT_DATA) || (state == RETRY);
    assign tmo_hit = ((state == WAIT_TX) || (state == WAIT_DATA)) && (tmo_cnt == TMO_LAST);
    assign id_rise = identify_done && !id_prev;
    assign launch  = (state_nxt == SEND) && (state != SEND);

    // Next state; link loss overrides everything, and pass/fail events beat the timeout.
    always_comb begin
        state_nxt     = state;
        cause_nxt     = cause_q;
        accept        = 1'b0;
        abort         = 1'b0;
        fail_code_vld = 1'b0;
        fail_code     = ERR_NONE;
        if (busy && !link_ready) begin
            abort         = 1'b1;
            state_nxt     = FAIL;
            fail_code_vld = 1'b1;
            fail_code     = ((state == SEND) || (state == WAIT_TX)) ? ERR_TX : ERR_TIMEOUT;
        end else begin
            case (state)
                IDLE: begin
                    if (start_eff) begin
                        accept = 1'b1;
                        if (link_ready) begin
                            state_nxt = SEND;
                        end else begin
                            state_nxt     = FAIL;
                            fail_code_vld = 1'b1;
                            fail_code     = ERR_TX;
                        end
                    end
                end
                SEND: if (tx_sent) state_nxt = WAIT_TX;
                WAIT_TX: begin
                    if (tx_fail) begin
                        state_nxt = RETRY;
                        cause_nxt = ERR_TX;
                    end else if (tx_done) begin
                        state_nxt = WAIT_DATA;
                    end else if (tmo_hit) begin
                        state_nxt = RETRY;
                        cause_nxt = ERR_TIMEOUT;
                    end
                end
                WAIT_DATA: begin
                    if (id_rise) begin
                        if (bad_checksum) begin
                            state_nxt = RETRY;
                            cause_nxt = ERR_CRC;
                        end else begin
                            state_nxt = DONE;
                        end
                    end else if (tmo_hit) begin
                        state_nxt = RETRY;
                        cause_nxt = ERR_TIMEOUT;
                    end
                end
                RETRY:   state_nxt = (attempt_cnt == RETRY_LIMIT) ? FAIL : SEND;
                DONE:    state_nxt = IDLE;
                FAIL:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Sticky status: cleared on an accepted start, direct-to-FAIL codes override the retry cause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done        <= 1'b0;
            error       <= 1'b0;
            error_code  <= ERR_NONE;
            attempt_cnt <= 2'd0;
            cause_q     <= ERR_NONE;
        end else begin
            cause_q <= cause_nxt;
            if (accept) begin
                done        <= 1'b0;
                error       <= 1'b0;
                error_code  <= ERR_NONE;
                attempt_cnt <= 2'd0;
            end
            if (state == RETRY) begin
                error_code <= cause_q;
                if ((state_nxt == SEND) && (attempt_cnt != 2'd3)) attempt_cnt <= attempt_cnt + 2'd1;
            end
            if (fail_code_vld)       error_code <= fail_code;
            if (state_nxt == DONE)   done       <= 1'b1;
            if (state_nxt == FAIL)   error      <= 1'b1;
        end
    end

    // Per-attempt timeout and identify_done history, both restarted when a FIS launches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            id_prev <= 1'b0;
        end else begin
            if (launch) begin
                tmo_cnt <= '0;
                id_prev <= 1'b0;
            end else begin
                id_prev <= identify_done;
                if (((state == WAIT_TX) || (state == WAIT_DATA)) && (tmo_cnt != TMO_LAST))
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    sata_reg_h2d_fis_tx u_fis_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .launch  (launch),
        .abort   (abort),
        .fis     (identify_fis),
        .cmd_dat (cmd_dat),
        .cmd_val (cmd_val),
        .cmd_eop (cmd_eop),
        .cmd_rdy (cmd_rdy),
        .sent    (tx_sent)
    );

endmodule
